// File: rtl/spi_pkg.sv
// Shared SPI definitions used by serializer and spi_deserializer: receiver
// state encoding and the fixed link mode (mode 0, LSB first).
package spi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } spi_state_t;

    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Single-bit 2-flop synchronizer with a configurable synchronous reset value.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    // NOTE: flops take non-blocking assignments so every stage samples its
    // input from before the edge; blocking here would collapse the chain.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/spi_deserializer.sv
// SPI mode-0 receiver: assembles LSB-first DATA_SIZE-bit words from CS/SCLK/MOSI.
// Define SPI_DESER_SYNC_EN to add 2-flop synchronizers on the pins (3-clock latency).
module spi_deserializer
    import spi_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_CS,
    input  logic                 i_SCLK,
    input  logic                 i_MOSI,
    output logic [DATA_SIZE-1:0] o_Data,
    output logic                 o_Data_Valid,
    output logic                 o_Busy,
    output logic                 o_Frame_Error
);

    localparam int              CNT_W    = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic w_cs;
    logic w_sclk;
    logic w_mosi;

`ifdef SPI_DESER_SYNC_EN
    // Stale reset values must drain through both sync stages and the edge register.
    localparam logic [1:0] SETTLE = 2'd3;

    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_D(i_CS),   .o_Q(w_cs)
    );
    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_D(i_SCLK), .o_Q(w_sclk)
    );
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_D(i_MOSI), .o_Q(w_mosi)
    );
`else
    localparam logic [1:0] SETTLE = 2'd1;

    assign w_cs   = i_CS;
    assign w_sclk = i_SCLK;
    assign w_mosi = i_MOSI;
`endif

    logic       r_cs;
    logic       r_cs_prev;
    logic       r_sclk;
    logic       r_sclk_prev;
    logic       r_mosi;
    logic [1:0] r_settle;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_cs        <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_sclk      <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi      <= 1'b0;
            r_settle    <= 2'd0;
        end else begin
            r_cs        <= w_cs;
            r_cs_prev   <= r_cs;
            r_sclk      <= w_sclk;
            r_sclk_prev <= r_sclk;
            r_mosi      <= w_mosi;
            if (r_settle != SETTLE)
                r_settle <= r_settle + 2'd1;
        end
    end

    logic w_sclk_lvl;
    logic w_sclk_lvl_prev;
    logic w_sclk_rise;
    logic w_cs_rise;
    logic w_cs_fall;

    assign w_sclk_lvl      = r_sclk ^ SPI_CPOL;
    assign w_sclk_lvl_prev = r_sclk_prev ^ SPI_CPOL;
    assign w_sclk_rise     = SPI_CPHA ? (~w_sclk_lvl & w_sclk_lvl_prev)
                                      : (w_sclk_lvl & ~w_sclk_lvl_prev);
    assign w_cs_rise       = r_cs & ~r_cs_prev;
    assign w_cs_fall       = ~r_cs & r_cs_prev;

    spi_state_t           r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_SIZE-1:0] r_shift;
    logic                 r_overrun;
    logic [CNT_W-1:0]     w_bit_idx;
    logic [DATA_SIZE-1:0] w_shift_next;

    assign w_bit_idx = SPI_LSB_FIRST ? r_bit_cnt : (CNT_LAST - r_bit_cnt);

    // NOTE: the default copy first keeps this block purely combinational;
    // a path that left w_shift_next unassigned would infer a latch.
    always_comb begin
        w_shift_next            = r_shift;
        w_shift_next[w_bit_idx] = r_mosi;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state       <= ST_WAIT_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_overrun     <= 1'b0;
            o_Data        <= '0;
            o_Data_Valid  <= 1'b0;
            o_Busy        <= 1'b0;
            o_Frame_Error <= 1'b0;
        end else begin
            o_Data_Valid  <= 1'b0;
            o_Frame_Error <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: begin
                    if (r_settle == SETTLE && r_cs)
                        r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        o_Busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // CS rise wins over a coincident SCLK rise and ends the frame.
                    if (w_cs_rise) begin
                        o_Frame_Error <= 1'b1;
                        o_Busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == CNT_LAST) begin
                            o_Data       <= w_shift_next;
                            o_Data_Valid <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_cs_rise) begin
                        o_Frame_Error <= r_overrun;
                        r_overrun     <= 1'b0;
                        o_Busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer: random frames of varying length
// scored against a frame-level model of what the receiver must report.
module tb_spi_deserializer;

    localparam int DW = 32;
`ifdef SPI_DESER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          i_Reset;
    logic          i_CS;
    logic          i_SCLK;
    logic          i_MOSI;
    logic [DW-1:0] o_Data;
    logic          o_Data_Valid;
    logic          o_Busy;
    logic          o_Frame_Error;

    always #5 clk = ~clk;

    spi_deserializer #(.DATA_SIZE(DW)) dut (
        .i_Clock      (clk),
        .i_Reset      (i_Reset),
        .i_CS         (i_CS),
        .i_SCLK       (i_SCLK),
        .i_MOSI       (i_MOSI),
        .o_Data       (o_Data),
        .o_Data_Valid (o_Data_Valid),
        .o_Busy       (o_Busy),
        .o_Frame_Error(o_Frame_Error)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [DW-1:0] q_words[$];
    int            q_vcyc[$];
    int            err_seen   = 0;
    int            wide_seen  = 0;
    logic          prev_valid = 1'b0;

    always @(negedge clk) begin
        if (o_Data_Valid) begin
            q_words.push_back(o_Data);
            q_vcyc.push_back(cyc);
        end
        if (o_Frame_Error) err_seen <= err_seen + 1;
        if (o_Data_Valid && prev_valid) wide_seen <= wide_seen + 1;
        prev_valid <= o_Data_Valid;
    end

    logic [DW-1:0] model_data;
    int            rise_cyc[64];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_bit(input int idx, input logic b);
        i_MOSI = b;
        wait_clk(2);
        i_SCLK = 1'b1;
        rise_cyc[idx] = cyc;
        wait_clk(4);
        i_SCLK = 1'b0;
        wait_clk(2);
    endtask

    // Frame-level model: exactly DW rises deliver a word, fewer give an error
    // and no word, more give the word from the first DW bits and then an error.
    task automatic run_frame(input string name, input logic [63:0] bits,
                             input int n, input bit chk_lat);
        int   w0, e0, nw;
        logic exp_valid, exp_err;
        w0 = q_words.size();
        e0 = err_seen;
        exp_valid = (n >= DW);
        exp_err   = (n != DW);

        i_CS = 1'b0;
        wait_clk(6);
        tests_run++;
        if (o_Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_mid: got %b expected 1", name, o_Busy);
        end
        for (int i = 0; i < n; i++) sclk_bit(i, bits[i]);
        wait_clk(3);
        i_CS = 1'b1;
        wait_clk(6);

        if (exp_valid) model_data = bits[DW-1:0];
        nw = q_words.size() - w0;

        tests_run++;
        if (nw != (exp_valid ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, nw, exp_valid ? 1 : 0);
        end
        if (exp_valid && nw > 0) begin
            tests_run++;
            if (q_words[w0] !== bits[DW-1:0]) begin
                tests_failed++;
                $display("FAIL %s word: got %h expected %h", name, q_words[w0], bits[DW-1:0]);
            end
            if (chk_lat) begin
                tests_run++;
                if (q_vcyc[w0] != rise_cyc[DW-1] + 1 + LAT) begin
                    tests_failed++;
                    $display("FAIL %s latency: got cycle %0d expected %0d",
                             name, q_vcyc[w0], rise_cyc[DW-1] + 1 + LAT);
                end
            end
        end
        tests_run++;
        if (o_Data !== model_data) begin
            tests_failed++;
            $display("FAIL %s data_held: got %h expected %h", name, o_Data, model_data);
        end
        tests_run++;
        if (err_seen - e0 != (exp_err ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL %s frame_error: got %0d expected %0d", name, err_seen - e0, exp_err ? 1 : 0);
        end
        tests_run++;
        if (o_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_after: got %b expected 0", name, o_Busy);
        end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        i_CS    = 1'b1;
        i_SCLK  = 1'b0;
        i_MOSI  = 1'b0;
        model_data = '0;
        wait_clk(4);
        tests_run++;
        if ({o_Data, o_Data_Valid, o_Busy, o_Frame_Error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got data=%h v=%b b=%b e=%b expected all 0",
                     o_Data, o_Data_Valid, o_Busy, o_Frame_Error);
        end
        i_Reset = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_loopback();
        run_frame("loopback_a5a50f0f", 64'hA5A50F0F, DW, 1'b1);
        for (int k = 0; k < 4; k++)
            run_frame("random_word", {$urandom, $urandom}, DW, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 64'h0000_0001, DW, 1'b0);
        run_frame("b2b_second", 64'h8000_0000, DW, 1'b0);
    endtask

    task automatic test_short_frame();
        run_frame("short_17", {$urandom, $urandom}, 17, 1'b0);
        run_frame("short_1", {$urandom, $urandom}, 1, 1'b0);
    endtask

    task automatic test_long_frame();
        run_frame("long_33", {$urandom, $urandom}, 33, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int w0, e0;
        e0 = err_seen;
        i_CS = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 10; i++) sclk_bit(i, 1'($urandom));
        i_Reset = 1'b1;
        wait_clk(2);
        tests_run++;
        if ({o_Data, o_Data_Valid, o_Busy, o_Frame_Error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got data=%h v=%b b=%b e=%b expected all 0",
                     o_Data, o_Data_Valid, o_Busy, o_Frame_Error);
        end
        i_Reset = 1'b0;
        model_data = '0;
        w0 = q_words.size();
        for (int i = 0; i < DW + 2; i++) sclk_bit(i, 1'($urandom));
        wait_clk(4);
        tests_run++;
        if (q_words.size() != w0 || err_seen != e0 || o_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: got words=%0d errs=%0d busy=%b expected 0 0 0",
                     q_words.size() - w0, err_seen - e0, o_Busy);
        end
        i_CS = 1'b1;
        wait_clk(8);
        run_frame("after_reset", {$urandom, $urandom}, DW, 1'b1);
    endtask

    task automatic test_edge_coincidence();
        int w0, e0;
        w0 = q_words.size();
        e0 = err_seen;
        i_CS = 1'b0;
        wait_clk(6);
        for (int i = 0; i < DW - 1; i++) sclk_bit(i, 1'($urandom));
        i_MOSI = 1'b1;
        wait_clk(2);
        i_SCLK = 1'b1;
        i_CS   = 1'b1;
        wait_clk(4);
        i_SCLK = 1'b0;
        wait_clk(6);
        tests_run++;
        if (q_words.size() != w0) begin
            tests_failed++;
            $display("FAIL coincide_no_word: got %0d words expected 0", q_words.size() - w0);
        end
        tests_run++;
        if (err_seen - e0 != 1) begin
            tests_failed++;
            $display("FAIL coincide_error: got %0d expected 1", err_seen - e0);
        end
        tests_run++;
        if (o_Data !== model_data || o_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincide_state: got data=%h busy=%b expected %h 0",
                     o_Data, o_Busy, model_data);
        end
    endtask

    task automatic test_pulse_width();
        tests_run++;
        if (wide_seen != 0) begin
            tests_failed++;
            $display("FAIL valid_width: got %0d multi-cycle pulses expected 0", wide_seen);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_edge_coincidence();
        test_pulse_width();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
